id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage_if.sv | 58 +++++
 rtl/id_ex_stage.sv | 100 ++++++++++
 tb/tb_id_ex_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields in, registered EX fields and hazard status out.
// The ID side drives through master; id_ex_stage takes the slave view.
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
);
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic              id_reg_write;
    logic              id_mem_read;
    logic [CTRL_W-1:0] id_ctrl;
    logic              ex_flush;
    logic              wb_reg_write;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;

    logic              stall;
    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [XLEN-1:0]   ex_imm;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [15:0]       stall_cnt;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd,
        output id_uses_rs1, id_uses_rs2, id_rs1_data, id_rs2_data,
        output id_imm, id_reg_write, id_mem_read, id_ctrl,
        output ex_flush, wb_reg_write, wb_rd, wb_data,
        input  stall, ex_valid, ex_reg_write, ex_mem_read,
        input  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        input  ex_rs1, ex_rs2, ex_rd, ex_ctrl, stall_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd,
        input  id_uses_rs1, id_uses_rs2, id_rs1_data, id_rs2_data,
        input  id_imm, id_reg_write, id_mem_read, id_ctrl,
        input  ex_flush, wb_reg_write, wb_rd, wb_data,
        output stall, ex_valid, ex_reg_write, ex_mem_read,
        output ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        output ex_rs1, ex_rs2, ex_rd, ex_ctrl, stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubble and stall counter.
// Optional: define ID_EX_WB_BYPASS_EN to forward the WB write into captured operands.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    logic              valid_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   rs1_data_q;
    logic [XLEN-1:0]   rs2_data_q;
    logic [XLEN-1:0]   imm_q;
    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;
    logic [4:0]        rd_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [15:0]       cnt_q;

    logic            src_hit;
    logic            hazard;
    logic            stall;
    logic [XLEN-1:0] rs1_cap;
    logic [XLEN-1:0] rs2_cap;

    assign src_hit = (bus.id_uses_rs1 && bus.id_rs1 == rd_q)
                  || (bus.id_uses_rs2 && bus.id_rs2 == rd_q);
    assign hazard  = valid_q && mem_read_q && rd_q != 5'd0
                  && bus.id_valid && src_hit;
    assign stall   = hazard && !bus.ex_flush;

`ifdef ID_EX_WB_BYPASS_EN
    logic wb_hit;
    assign wb_hit  = bus.wb_reg_write && bus.wb_rd != 5'd0;
    assign rs1_cap = (wb_hit && bus.wb_rd == bus.id_rs1)
                   ? bus.wb_data : bus.id_rs1_data;
    assign rs2_cap = (wb_hit && bus.wb_rd == bus.id_rs2)
                   ? bus.wb_data : bus.id_rs2_data;
`else
    logic unused_wb;
    assign unused_wb = ^{bus.wb_reg_write, bus.wb_rd, bus.wb_data};
    assign rs1_cap   = bus.id_rs1_data;
    assign rs2_cap   = bus.id_rs2_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || bus.ex_flush || hazard) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            ctrl_q      <= '0;
        end else begin
            // Invalid slots keep their fields but must never write or load.
            valid_q     <= bus.id_valid;
            reg_write_q <= bus.id_valid && bus.id_reg_write;
            mem_read_q  <= bus.id_valid && bus.id_mem_read;
            ctrl_q      <= bus.id_valid ? bus.id_ctrl : '0;
            pc_q        <= bus.id_pc;
            rs1_data_q  <= rs1_cap;
            rs2_data_q  <= rs2_cap;
            imm_q       <= bus.id_imm;
            rs1_q       <= bus.id_rs1;
            rs2_q       <= bus.id_rs2;
            rd_q        <= bus.id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.stall        = stall;
    assign bus.ex_valid     = valid_q;
    assign bus.ex_reg_write = reg_write_q;
    assign bus.ex_mem_read  = mem_read_q;
    assign bus.ex_pc        = pc_q;
    assign bus.ex_rs1_data  = rs1_data_q;
    assign bus.ex_rs2_data  = rs2_data_q;
    assign bus.ex_imm       = imm_q;
    assign bus.ex_rs1       = rs1_q;
    assign bus.ex_rs2       = rs2_q;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_ctrl      = ctrl_q;
    assign bus.stall_cnt    = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reference model checked every negedge plus literal pins.
// Honours ID_EX_WB_BYPASS_EN the same way the design does.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(32), .CTRL_W(8)) bus ();

    id_ex_stage #(.XLEN(32), .CTRL_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mr;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } ex_t;

    ex_t m = '0;
    int  m_cnt = 0;
    int  tests = 0;
    int  fails = 0;
    bit  chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A load in EX blocks any ID instruction that reads its destination.
    function automatic bit m_hazard();
        if (!(m.valid && m.mr && m.rd != 0 && bus.id_valid)) return 0;
        if (bus.id_uses_rs1 && bus.id_rs1 == m.rd) return 1;
        if (bus.id_uses_rs2 && bus.id_rs2 == m.rd) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_operand(input logic [4:0] idx,
                                               input logic [31:0] rf);
`ifdef ID_EX_WB_BYPASS_EN
        if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == idx)
            return bus.wb_data;
`endif
        return rf;
    endfunction

    always @(posedge clk) begin
        bit h;
        bit s;
        h = m_hazard();
        s = h && !bus.ex_flush;
        if (!rst_n) begin
            m = '0;
            m_cnt = 0;
        end else begin
            if (s) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (bus.ex_flush || h) begin
                m = '0;
            end else begin
                m.valid = bus.id_valid;
                m.rw    = bus.id_valid ? bus.id_reg_write : 1'b0;
                m.mr    = bus.id_valid ? bus.id_mem_read : 1'b0;
                m.ctrl  = bus.id_valid ? bus.id_ctrl : 8'h00;
                m.pc    = bus.id_pc;
                m.imm   = bus.id_imm;
                m.rs1   = bus.id_rs1;
                m.rs2   = bus.id_rs2;
                m.rd    = bus.id_rd;
                m.d1    = m_operand(bus.id_rs1, bus.id_rs1_data);
                m.d2    = m_operand(bus.id_rs2, bus.id_rs2_data);
            end
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", bus.stall, m_hazard() && !bus.ex_flush);
            check("ex_valid", bus.ex_valid, m.valid);
            check("ex_reg_write", bus.ex_reg_write, m.rw);
            check("ex_mem_read", bus.ex_mem_read, m.mr);
            check("ex_pc", bus.ex_pc, m.pc);
            check("ex_rs1_data", bus.ex_rs1_data, m.d1);
            check("ex_rs2_data", bus.ex_rs2_data, m.d2);
            check("ex_imm", bus.ex_imm, m.imm);
            check("ex_rs1", bus.ex_rs1, m.rs1);
            check("ex_rs2", bus.ex_rs2, m.rs2);
            check("ex_rd", bus.ex_rd, m.rd);
            check("ex_ctrl", bus.ex_ctrl, m.ctrl);
            check("stall_cnt", bus.stall_cnt, m_cnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1,
                          input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr);
        bus.id_valid     = 1'b1;
        bus.id_pc        = pc;
        bus.id_rs1       = rs1;
        bus.id_uses_rs1  = u1;
        bus.id_rs2       = rs2;
        bus.id_uses_rs2  = u2;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
    endtask

    logic [31:0] byp_exp;

    initial begin
        bus.ex_flush     = 1'b0;
        bus.wb_reg_write = 1'b0;
        bus.wb_rd        = 5'd0;
        bus.wb_data      = 32'h0;
        bus.id_rs1_data  = 32'h11;
        bus.id_rs2_data  = 32'h22;
        bus.id_imm       = 32'h10;
        bus.id_ctrl      = 8'h5A;
        set_id(32'h100, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);

        // reset held with a valid instruction present
        cyc();
        cyc();
        check("rst ex_valid", bus.ex_valid, 1'b0);
        check("rst ex_pc", bus.ex_pc, 32'h0);
        check("rst stall", bus.stall, 1'b0);
        check("rst stall_cnt", bus.stall_cnt, 16'd0);

        rst_n = 1'b1;
        cyc();
        check("cap ex_valid", bus.ex_valid, 1'b1);
        check("cap ex_pc", bus.ex_pc, 32'h100);
        check("cap ex_rs1", bus.ex_rs1, 5'd5);
        check("cap ex_rs2", bus.ex_rs2, 5'd6);
        check("cap ex_rd", bus.ex_rd, 5'd7);
        check("cap ex_imm", bus.ex_imm, 32'h10);
        check("cap ex_reg_write", bus.ex_reg_write, 1'b1);

        // lw x3 followed by a dependent add
        set_id(32'h104, 5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        cyc();
        set_id(32'h108, 5'd3, 1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        check("lu stall", bus.stall, 1'b1);
        cyc();
        check("lu bubble valid", bus.ex_valid, 1'b0);
        check("lu bubble rd", bus.ex_rd, 5'd0);
        check("lu stall_cnt", bus.stall_cnt, 16'd1);
        check("lu stall drop", bus.stall, 1'b0);
        cyc();
        check("lu add valid", bus.ex_valid, 1'b1);
        check("lu add pc", bus.ex_pc, 32'h108);
        check("lu add rs1", bus.ex_rs1, 5'd3);

        // rs2 matches but is not read
        set_id(32'h10C, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        cyc();
        set_id(32'h110, 5'd1, 1'b1, 5'd9, 1'b0, 5'd10, 1'b1, 1'b0);
        #1;
        check("no-use rs2 stall", bus.stall, 1'b0);
        cyc();
        check("no-use rs2 valid", bus.ex_valid, 1'b1);

        // load to x0
        set_id(32'h114, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        cyc();
        set_id(32'h118, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0);
        #1;
        check("x0 load stall", bus.stall, 1'b0);
        cyc();

        // flush wins over the hazard
        set_id(32'h11C, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        cyc();
        set_id(32'h120, 5'd3, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        bus.ex_flush = 1'b1;
        #1;
        check("flush stall", bus.stall, 1'b0);
        cyc();
        bus.ex_flush = 1'b0;
        check("flush bubble valid", bus.ex_valid, 1'b0);
        check("flush stall_cnt", bus.stall_cnt, 16'd1);

        // WB bypass into rs1
`ifdef ID_EX_WB_BYPASS_EN
        byp_exp = 32'hDEADBEEF;
`else
        byp_exp = 32'h0;
`endif
        set_id(32'h124, 5'd4, 1'b1, 5'd6, 1'b1, 5'd13, 1'b1, 1'b0);
        bus.id_rs1_data  = 32'h0;
        bus.wb_reg_write = 1'b1;
        bus.wb_rd        = 5'd4;
        bus.wb_data      = 32'hDEADBEEF;
        cyc();
        check("bypass rs1", bus.ex_rs1_data, byp_exp);
        check("bypass rs2 untouched", bus.ex_rs2_data, 32'h22);

        bus.wb_rd       = 5'd0;
        bus.id_rs1      = 5'd0;
        bus.id_rs1_data = 32'h77;
        cyc();
        check("bypass x0", bus.ex_rs1_data, 32'h77);
        bus.wb_reg_write = 1'b0;

        // invalid slot: controls zeroed, fields still captured
        bus.id_valid = 1'b0;
        bus.id_pc    = 32'h128;
        cyc();
        check("inv valid", bus.ex_valid, 1'b0);
        check("inv reg_write", bus.ex_reg_write, 1'b0);
        check("inv ctrl", bus.ex_ctrl, 8'h00);
        check("inv pc", bus.ex_pc, 32'h128);

        // reset in the middle of a stall
        set_id(32'h12C, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        cyc();
        set_id(32'h130, 5'd5, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
        #1;
        check("pre-rst stall", bus.stall, 1'b1);
        rst_n = 1'b0;
        cyc();
        check("mid-rst stall", bus.stall, 1'b0);
        check("mid-rst ex_rd", bus.ex_rd, 5'd0);
        check("mid-rst stall_cnt", bus.stall_cnt, 16'd0);
        rst_n = 1'b1;
        cyc();
        check("post-rst pc", bus.ex_pc, 32'h130);
        cyc();

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
